// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_req_ready;
  logic [31:0] icache_dout;
  logic        icache_resp_valid;
  logic        icache_resp_ready;

  modport master (
    output icache_addr,
    output icache_re,
    output icache_resp_ready,
    input  icache_req_ready,
    input  icache_dout,
    input  icache_resp_valid
  );

  modport slave (
    input  icache_addr,
    input  icache_re,
    input  icache_resp_ready,
    output icache_req_ready,
    output icache_dout,
    output icache_resp_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: takes pc_in from PC, fetches over the icache request/
// response pair (ic), holds the instruction for decode, stalls PC
// until delivery and flushes wrong-path work on pc_sel.
// Ports: clk, reset (sync, active-high), pc_in, pc_sel, stall_in,
// fetch_stall, ic (fetch_unit_if.master), inst_out, inst_pc, inst_valid.
// Optional: define FETCH_PERF_EN for perf_fetch_cnt, perf_stall_cnt,
// perf_flush_cnt counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc_in,
  input  logic         pc_sel,
  input  logic         stall_in,
  output logic         fetch_stall,
  fetch_unit_if.master ic,
  output logic [31:0]  inst_out,
  output logic [31:0]  inst_pc,
  output logic         inst_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_flush_cnt
`endif
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ipc_q, ipc_d;

  logic req_hs;
  logic resp_hs;
  logic deliver;

  assign ic.icache_addr = pc_in;
  assign ic.icache_re   = !reset && (state_q == S_REQ);

  // Discarded responses are always accepted; live ones only
  // when the output slot is free or being drained this edge.
  assign ic.icache_resp_ready = !reset
                              && (state_q == S_WAIT)
                              && (discard_q || !valid_q || !stall_in);

  assign req_hs  = ic.icache_re && ic.icache_req_ready;
  assign resp_hs = ic.icache_resp_ready && ic.icache_resp_valid;
  assign deliver = resp_hs && !discard_q && !pc_sel;

  // PC moves on a redirect or once per captured instruction.
  assign fetch_stall = reset
                     || !(pc_sel || (resp_hs && !discard_q));

  assign inst_out   = inst_q;
  assign inst_pc    = ipc_q;
  assign inst_valid = valid_q;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    req_pc_d  = req_pc_q;
    valid_d   = valid_q;
    inst_d    = inst_q;
    ipc_d     = ipc_q;

    if (valid_q && !stall_in) valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
        if (req_hs) begin
          req_pc_d  = pc_in;
          state_d   = S_WAIT;
          discard_d = pc_sel;
        end
      end
      S_WAIT: begin
        if (pc_sel) discard_d = 1'b1;
        if (resp_hs) begin
          state_d   = S_REQ;
          discard_d = 1'b0;
          if (deliver) begin
            inst_d  = ic.icache_dout;
            ipc_d   = req_pc_q;
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = S_REQ;
    endcase

    if (pc_sel) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_REQ;
      discard_q <= 1'b0;
      req_pc_q  <= RESET_PC;
      valid_q   <= 1'b0;
      inst_q    <= NOP_INST;
      ipc_q     <= RESET_PC;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_pc_q  <= req_pc_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      ipc_q     <= ipc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] pf_fetch_q;
  logic [31:0] pf_stall_q;
  logic [31:0] pf_flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pf_fetch_q <= '0;
      pf_stall_q <= '0;
      pf_flush_q <= '0;
    end else begin
      if (deliver)     pf_fetch_q <= pf_fetch_q + 32'd1;
      if (fetch_stall) pf_stall_q <= pf_stall_q + 32'd1;
      if (pc_sel)      pf_flush_q <= pf_flush_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = pf_fetch_q;
  assign perf_stall_cnt = pf_stall_q;
  assign perf_flush_cnt = pf_flush_q;
`endif

endmodule
